// File: rtl/writeback_unit_if.sv
// Writeback port bundle: ALU/load results in, register-file write port,
// scoreboard and FIFO status out.
interface writeback_unit_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [3:0]    alu_rz;
  logic [15:0]   alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [3:0]    ld_rz;
  logic [15:0]   ld_data;
  logic          issue_valid;
  logic [3:0]    issue_rz;
  logic          reg_wr;
  logic [3:0]    addr_Rz;
  logic [15:0]   write_data;
  logic [15:0]   pending;
  logic [CW-1:0] fifo_count;
  logic          wb_err;

  // Execute/load/issue side
  modport master (
    output alu_valid, alu_rz, alu_data,
    output ld_valid, ld_rz, ld_data,
    output issue_valid, issue_rz,
    input  ld_ready, reg_wr, addr_Rz, write_data, pending, fifo_count, wb_err
  );

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rz, alu_data,
    input  ld_valid, ld_rz, ld_data,
    input  issue_valid, issue_rz,
    output ld_ready, reg_wr, addr_Rz, write_data, pending, fifo_count, wb_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results with queued load results onto the
// register-file write port and tracks per-register outstanding writes.
module writeback_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  writeback_unit_if.slave  wb
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned RW   = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 16;

  typedef struct packed {
    logic [RW-1:0] rz;
    logic [DW-1:0] data;
  } ld_entry_t;

  ld_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_reg_wr;
  logic [RW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [NREG-1:0] r_pending;
  logic            r_err;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_sel;
  logic [RW-1:0]   w_sel_rz;
  logic [DW-1:0]   w_sel_data;
  ld_entry_t       w_head;
  logic [CW-1:0]   w_count_nxt;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_err_hit;

  // FIFO status and handshake; a same-cycle pop never frees a slot for the push
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_head  = r_mem[r_rd_ptr];
    w_push  = wb.ld_valid & ~w_full;
    w_pop   = ~wb.alu_valid & ~w_empty;
  end

  // Source select: ALU always wins, FIFO head waits
  always_comb begin
    w_sel      = 1'b0;
    w_sel_rz   = '0;
    w_sel_data = '0;
    if (wb.alu_valid) begin
      w_sel      = 1'b1;
      w_sel_rz   = wb.alu_rz;
      w_sel_data = wb.alu_data;
    end else if (!w_empty) begin
      w_sel      = 1'b1;
      w_sel_rz   = w_head.rz;
      w_sel_data = w_head.data;
    end
  end

  // Occupancy and scoreboard next-state; issue set overrides writeback clear
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_set = '0;
    w_clr = '0;
    if (wb.issue_valid) w_set = NREG'(1) << wb.issue_rz;
    if (w_sel)          w_clr = NREG'(1) << w_sel_rz;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_err_hit     = w_sel & ~r_pending[w_sel_rz];
  end

  // Load storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{rz: wb.ld_rz, data: wb.ld_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Register-file write port; address/data hold when nothing is selected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_wr <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_reg_wr <= w_sel;
      if (w_sel) begin
        r_addr <= w_sel_rz;
        r_data <= w_sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_err_hit) r_err <= 1'b1;
    end
  end

  assign wb.ld_ready   = ~w_full;
  assign wb.reg_wr     = r_reg_wr;
  assign wb.addr_Rz    = r_addr;
  assign wb.write_data = r_data;
  assign wb.pending    = r_pending;
  assign wb.fifo_count = r_count;
  assign wb.wb_err     = r_err;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, all
// checked against a queue-based model of the writeback rules.
module tb_writeback_unit;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset_n;

  writeback_unit_if #(.DEPTH(DEPTH)) wb ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [19:0] m_q[$];
  logic [15:0] m_pend;
  logic        m_err;
  logic        m_wr;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = '0;
    m_err  = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock cycle: drive inputs, check ld_ready, advance model, check outputs
  task automatic step(input logic rn,
                      input logic av, input logic [3:0] ar, input logic [15:0] ad,
                      input logic lv, input logic [3:0] lr, input logic [15:0] ld,
                      input logic iv, input logic [3:0] ir);
    logic        acc;
    logic        sel;
    logic [3:0]  srz;
    logic [15:0] sdat;
    logic [19:0] e;
    reset_n        = rn;
    wb.alu_valid   = av;
    wb.alu_rz      = ar;
    wb.alu_data    = ad;
    wb.ld_valid    = lv;
    wb.ld_rz       = lr;
    wb.ld_data     = ld;
    wb.issue_valid = iv;
    wb.issue_rz    = ir;
    #1;
    if (!rn) model_reset();
    chk("ld_ready", 32'(wb.ld_ready), 32'(m_q.size() != DEPTH));
    if (rn) begin
      acc  = lv && (m_q.size() < DEPTH);
      sel  = 1'b0;
      srz  = '0;
      sdat = '0;
      if (av) begin
        sel = 1'b1; srz = ar; sdat = ad;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        sel = 1'b1; srz = e[19:16]; sdat = e[15:0];
      end
      if (acc) m_q.push_back({lr, ld});
      if (sel) begin
        if (!m_pend[srz]) m_err = 1'b1;
        m_pend[srz] = 1'b0;
        m_addr = srz;
        m_data = sdat;
      end
      if (iv) m_pend[ir] = 1'b1;
      m_wr = sel;
    end
    @(posedge clk);
    #1;
    chk("reg_wr",     32'(wb.reg_wr),     32'(m_wr));
    chk("addr_Rz",    32'(wb.addr_Rz),    32'(m_addr));
    chk("write_data", 32'(wb.write_data), 32'(m_data));
    chk("pending",    32'(wb.pending),    32'(m_pend));
    chk("fifo_count", 32'(wb.fifo_count), 32'(m_q.size()));
    chk("wb_err",     32'(wb.wb_err),     32'(m_err));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  task automatic issue(input logic [3:0] r);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, r);
  endtask

  initial begin
    logic [15:0] saved [4];
    model_reset();

    // Reset values under random inputs
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
           4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
    chk("rst_reg_wr", 32'(wb.reg_wr), 32'd0);
    chk("rst_pending", 32'(wb.pending), 32'd0);
    chk("rst_ld_ready", 32'(wb.ld_ready), 32'd1);

    // ALU path
    issue(4'd3);
    step(1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("alu_wr", 32'(wb.reg_wr), 32'd1);
    chk("alu_addr", 32'(wb.addr_Rz), 32'd3);
    chk("alu_data", 32'(wb.write_data), 32'h1234);
    chk("alu_pend3", 32'(wb.pending[3]), 32'd0);
    chk("alu_err", 32'(wb.wb_err), 32'd0);

    // Load vs ALU arbitration
    issue(4'd5);
    issue(4'd6);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd6, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("arb_n2_addr", 32'(wb.addr_Rz), 32'd6);
    chk("arb_n2_data", 32'(wb.write_data), 32'h0001);
    idle();
    chk("arb_n3_addr", 32'(wb.addr_Rz), 32'd5);
    chk("arb_n3_data", 32'(wb.write_data), 32'hBEEF);

    // FIFO full and pointer wrap; ALU keeps rewriting R12 while reissuing it
    issue(4'd12);
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) issue(4'(8 + i));
      for (int i = 0; i < 4; i++) begin
        saved[i] = 16'($urandom);
        step(1'b1, 1'b1, 4'd12, 16'($urandom), 1'b1, 4'(8 + i), saved[i], 1'b1, 4'd12);
      end
      chk("full_count", 32'(wb.fifo_count), 32'd4);
      chk("full_ready", 32'(wb.ld_ready), 32'd0);
      step(1'b1, 1'b1, 4'd12, 16'($urandom), 1'b1, 4'd15, 16'hDEAD, 1'b1, 4'd12);
      chk("full_5th", 32'(wb.fifo_count), 32'd4);
      for (int i = 0; i < 4; i++) begin
        idle();
        chk("drain_wr", 32'(wb.reg_wr), 32'd1);
        chk("drain_addr", 32'(wb.addr_Rz), 32'(8 + i));
        chk("drain_data", 32'(wb.write_data), 32'(saved[i]));
      end
      chk("drain_empty", 32'(wb.fifo_count), 32'd0);
    end

    // Scoreboard: same-cycle set beats clear; unexpected write flags error
    issue(4'd7);
    step(1'b1, 1'b1, 4'd7, 16'h0707, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    chk("coll_pend7", 32'(wb.pending[7]), 32'd1);
    chk("pre_err", 32'(wb.wb_err), 32'd0);
    step(1'b1, 1'b1, 4'd9, 16'h0909, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("err_set", 32'(wb.wb_err), 32'd1);
    for (int i = 0; i < 3; i++) idle();
    chk("err_sticky", 32'(wb.wb_err), 32'd1);

    // Reset mid-operation with queued loads
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    for (int i = 4; i < 8; i++) issue(4'(i));
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'd0, 16'h0, 1'b1, 4'(4 + i), 16'($urandom), 1'b0, 4'd0);
    chk("mid_pend", 32'(wb.pending), 32'h00F0);
    chk("mid_count", 32'(wb.fifo_count), 32'd3);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    chk("mid_rst_count", 32'(wb.fifo_count), 32'd0);
    chk("mid_rst_pend", 32'(wb.pending), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("mid_no_wr", 32'(wb.reg_wr), 32'd0);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      step(1'(($urandom % 64) != 0),
           1'(($urandom % 3) == 0), 4'($urandom), 16'($urandom),
           1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
